// File: rtl/agc_pkg.sv
// agc_pkg -- shared definitions for the AGC pipelined core front end.
//
// Contents:
//   AGC_WIDTH / AGC_ADDR_W  default instruction word and address widths
//   RESET_PC                PC value loaded by reset ('o4000)
//   fetch_entry_t           one prefetched instruction together with its address
package agc_pkg;

  localparam int AGC_WIDTH  = 15;
  localparam int AGC_ADDR_W = 15;

  localparam logic [AGC_ADDR_W-1:0] RESET_PC = 15'o4000;

  typedef struct packed {
    logic [AGC_ADDR_W-1:0] pc;
    logic [AGC_WIDTH-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- DEPTH-entry synchronous FIFO with an explicit occupancy count.
//
// The count is stored, so full and empty are never confused even though
// the read and write pointers are equal in both cases.
//
// Ports:
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous, active-high; empties the FIFO
//   flush      in   1       synchronous empty request (same effect as reset)
//   push       in   1       write push_data this cycle
//   push_data  in   DW      data written on push
//   pop        in   1       advance the head this cycle
//   head_data  out  DW      current head entry (stale when empty)
//   not_empty  out  1       head_data holds a valid entry
//   count      out  CNT_W   entries currently held
module sync_fifo
  import agc_pkg::*;
#(
  parameter int DW    = 30,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop: never pop an empty FIFO, only push into a full one
  // when the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
    do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);
  end

  // Pointer and occupancy state; flush and reset both empty the FIFO.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because validity lives in count_r.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign not_empty = (count_r != {CNT_W{1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue -- fetch front end of the AGC pipelined core.
//
// Owns the PC, issues pipelined ROM reads and buffers the returned words in
// a DEPTH-entry queue ahead of decode. A read is only issued while
// (queued + in flight) < DEPTH, so every returning word has a slot waiting.
//
// Optional feature (macro FETCH_BYPASS_EN): a word arriving while the queue
// is empty and decode is ready is presented directly on instr/instr_pc in
// its arrival cycle and never written to the queue.
//
// Ports:
//   clock          in   1        rising-edge clock
//   reset          in   1        synchronous, active-high
//   rom_req        out  1        ROM read issued this cycle
//   rom_address    out  ADDR_W   read address, valid with rom_req
//   rom_read_data  in   WIDTH    data for the read issued ROM_LAT cycles ago
//   redirect_en    in   1        taken branch: flush and refetch
//   redirect_pc    in   ADDR_W   branch target
//   instr_valid    out  1        queue head valid
//   instr          out  WIDTH    queue head instruction
//   instr_pc       out  ADDR_W   address of the queue head
//   instr_ready    in   1        decode accepts the head
//   count          out  CNT_W    entries currently held in the queue
module fetch_queue
  import agc_pkg::*;
#(
  parameter int                WIDTH    = 15,
  parameter int                ADDR_W   = 15,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(agc_pkg::RESET_PC)
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       rom_req,
  output logic [ADDR_W-1:0]          rom_address,
  input  logic [WIDTH-1:0]           rom_read_data,
  input  logic                       redirect_en,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  output logic [WIDTH-1:0]           instr,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(ROM_LAT + 1);
  localparam int OCC_W = $clog2(DEPTH + ROM_LAT + 1);
  localparam int EW    = ADDR_W + WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WIDTH-1:0]  instr;
  } entry_t;

  logic [ADDR_W-1:0]  pc_r;
  logic [ROM_LAT-1:0] pipe_vld_r;
  logic [ADDR_W-1:0]  pipe_pc_r [ROM_LAT];

  logic               issue_s;
  logic               arrive_s;
  logic               bypass_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_valid_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic [INF_W-1:0]   inflight_s;
  logic [OCC_W-1:0]   occupancy_s;
  entry_t             push_entry_s;
  entry_t             head_entry_s;

  // Count reads still travelling through the ROM pipe.
  always_comb begin
    inflight_s = {INF_W{1'b0}};
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight_s = inflight_s + INF_W'(pipe_vld_r[i]);
    end
  end

  // Credit check, arrival, bypass and queue handshake decisions.
  always_comb begin
    occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_s);
    issue_s     = !reset && !redirect_en && (occupancy_s < OCC_W'(DEPTH));
    arrive_s    = pipe_vld_r[ROM_LAT-1] && !reset && !redirect_en;
`ifdef FETCH_BYPASS_EN
    bypass_s    = arrive_s && !fifo_valid_s && instr_ready;
`else
    bypass_s    = 1'b0;
`endif
    push_s      = arrive_s && !bypass_s;
    pop_s       = fifo_valid_s && instr_ready && !redirect_en && !reset;
    push_entry_s.pc    = pipe_pc_r[ROM_LAT-1];
    push_entry_s.instr = rom_read_data;
  end

  // PC and in-flight valid bits; redirect drops every outstanding read.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      pipe_vld_r <= {ROM_LAT{1'b0}};
    end else if (redirect_en) begin
      pc_r       <= redirect_pc;
      pipe_vld_r <= {ROM_LAT{1'b0}};
    end else begin
      if (issue_s) begin
        pc_r <= pc_r + ADDR_W'(1'b1);
      end
      pipe_vld_r[0] <= issue_s;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
      end
    end
  end

  // Address tags travelling alongside the valid bits; meaningful only when valid.
  always_ff @(posedge clock) begin
    pipe_pc_r[0] <= pc_r;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_pc_r[i] <= pipe_pc_r[i-1];
    end
  end

  sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_en),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head_data (head_entry_s),
    .not_empty (fifo_valid_s),
    .count     (fifo_count_s)
  );

  // Output selection; valid and count read as zero throughout a reset cycle.
  always_comb begin
    rom_req     = issue_s;
    rom_address = pc_r;
    if (bypass_s) begin
      instr_valid = 1'b1;
      instr       = rom_read_data;
      instr_pc    = pipe_pc_r[ROM_LAT-1];
    end else begin
      instr_valid = fifo_valid_s && !reset;
      instr       = head_entry_s.instr;
      instr_pc    = head_entry_s.pc;
    end
    if (reset) begin
      count = {CNT_W{1'b0}};
    end else begin
      count = fifo_count_s;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- self-checking bench for fetch_queue (DEPTH=4, ROM_LAT=3).
//
// A ROM model answers every request ROM_LAT cycles later with a scrambled
// copy of its address. A reference model tracks the fetch queue as a list of
// queued addresses plus a list of outstanding reads (address, issue cycle)
// and predicts every output each cycle. Directed scenarios are followed by
// a randomized phase.
module tb_fetch_queue;

  localparam int WIDTH  = 15;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 4;
  localparam int LAT    = 3;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int HN     = 2048;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VALID = LAT;
`else
  localparam int FIRST_VALID = LAT + 1;
`endif

  logic              clock;
  logic              reset;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_address;
  logic [WIDTH-1:0]  rom_read_data;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [WIDTH-1:0]  instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic [CNT_W-1:0]  count;

  fetch_queue #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ROM_LAT  (LAT),
    .RESET_PC (15'o4000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_req       (rom_req),
    .rom_address   (rom_address),
    .rom_read_data (rom_read_data),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .count         (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass;
  int n_total;
  int cyc;
  int n_req_seen;
  int last_valid;
  int last_count;

  logic              hist_req  [HN];
  logic [ADDR_W-1:0] hist_addr [HN];
  int                popped [$];

  // reference model state
  int m_pc;
  int m_q [$];
  int m_fl_addr [$];
  int m_fl_cyc [$];

  function automatic logic [WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] k;
    k = 15'h2AAA;
    return WIDTH'(a) ^ k;
  endfunction

  function automatic int pk(input int i);
    if (popped.size() > i) return popped[i];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, predict, compare at negedge, advance model.
  task automatic step(input logic rst, input logic redir, input logic [ADDR_W-1:0] rpc,
                      input logic rdy);
    logic e_req;
    logic e_valid;
    logic bypass;
    logic arriving;
    int   e_pc;
    int   e_cnt;
    reset       = rst;
    redirect_en = redir;
    redirect_pc = rpc;
    instr_ready = rdy;
    if (cyc >= LAT && hist_req[(cyc - LAT) % HN])
      rom_read_data = rom_word(hist_addr[(cyc - LAT) % HN]);
    else
      rom_read_data = WIDTH'($urandom);

    arriving = (m_fl_cyc.size() > 0) && (m_fl_cyc[0] + LAT == cyc) && !rst && !redir;
    e_req    = !rst && !redir && (m_q.size() + m_fl_cyc.size() < DEPTH);
    bypass   = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass   = arriving && (m_q.size() == 0) && rdy;
`endif
    e_valid  = !rst && ((m_q.size() > 0) || bypass);
    e_pc     = bypass ? m_fl_addr[0] : ((m_q.size() > 0) ? m_q[0] : 0);
    e_cnt    = rst ? 0 : m_q.size();

    @(negedge clock);
    check("rom_req", 32'(rom_req), 32'(e_req));
    if (e_req) check("rom_address", 32'(rom_address), m_pc);
    check("instr_valid", 32'(instr_valid), 32'(e_valid));
    if (e_valid) begin
      check("instr_pc", 32'(instr_pc), e_pc);
      check("instr", 32'(instr), 32'(rom_word(15'(e_pc))));
    end
    check("count", 32'(count), e_cnt);

    last_valid = int'(instr_valid);
    last_count = int'(count);
    hist_req[cyc % HN]  = rom_req;
    hist_addr[cyc % HN] = rom_address;
    if (rom_req) n_req_seen++;
    if (instr_valid && rdy && !redir && !rst) popped.push_back(int'(instr_pc));

    if (rst) begin
      m_q.delete(); m_fl_addr.delete(); m_fl_cyc.delete();
      m_pc = 'o4000;
    end else if (redir) begin
      m_q.delete(); m_fl_addr.delete(); m_fl_cyc.delete();
      m_pc = int'(rpc);
    end else begin
      if (e_valid && rdy && !bypass) void'(m_q.pop_front());
      if (arriving) begin
        if (!bypass) m_q.push_back(m_fl_addr[0]);
        void'(m_fl_addr.pop_front());
        void'(m_fl_cyc.pop_front());
      end
      if (e_req) begin
        m_fl_addr.push_back(m_pc);
        m_fl_cyc.push_back(cyc);
        m_pc = (m_pc + 1) % 32768;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int first;
    int k;
    n_pass = 0; n_total = 0; cyc = 0; n_req_seen = 0;
    last_valid = 0; last_count = 0; m_pc = 'o4000;
    for (int i = 0; i < HN; i++) begin hist_req[i] = 1'b0; hist_addr[i] = '0; end
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    rom_read_data = '0;
    @(posedge clock); #1;

    // reset state
    repeat (2) step(1'b1, 1'b0, 15'd0, 1'b0);

    // sequential fetch from 'o4000 and first-valid latency
    popped.delete();
    first = -1;
    for (k = 0; k < 20 && first < 0; k++) begin
      step(1'b0, 1'b0, 15'd0, 1'b1);
      if (last_valid != 0) first = k;
    end
    check("first_valid_cycle", 32'(first), FIRST_VALID);
    repeat (8) step(1'b0, 1'b0, 15'd0, 1'b1);
    for (int i = 0; i < 4; i++) check("seq_pc", 32'(pk(i)), 'o4000 + i);

    // decode stalled: exactly DEPTH requests, then drain in order
    step(1'b1, 1'b0, 15'd0, 1'b0);
    n_req_seen = 0;
    repeat (20) step(1'b0, 1'b0, 15'd0, 1'b0);
    check("stall_req_total", 32'(n_req_seen), DEPTH);
    check("stall_count", 32'(last_count), DEPTH);
    popped.delete();
    repeat (12) step(1'b0, 1'b0, 15'd0, 1'b1);
    for (int i = 0; i < 5; i++) check("drain_pc", 32'(pk(i)), 'o4000 + i);

    // redirect with a partly full queue and a read in flight
    step(1'b1, 1'b0, 15'd0, 1'b0);
    for (k = 0; k < 20 && last_count != 3; k++) step(1'b0, 1'b0, 15'd0, 1'b0);
    check("fill_to_3", 32'(last_count), 3);
    popped.delete();
    step(1'b0, 1'b1, 15'o2000, 1'b0);
    step(1'b0, 1'b0, 15'd0, 1'b1);
    check("redirect_flush_count", 32'(last_count), 0);
    repeat (10) step(1'b0, 1'b0, 15'd0, 1'b1);
    check("redirect_pc0", 32'(pk(0)), 'o2000);
    check("redirect_pc1", 32'(pk(1)), 'o2001);

    // redirect coinciding with a ready decode and a valid head
    for (k = 0; k < 20 && last_valid == 0; k++) step(1'b0, 1'b0, 15'd0, 1'b1);
    check("head_valid_before_redirect", 32'(last_valid), 1);
    popped.delete();
    step(1'b0, 1'b1, 15'o1234, 1'b1);
    repeat (8) step(1'b0, 1'b0, 15'd0, 1'b1);
    check("redirect_ready_pc", 32'(pk(0)), 'o1234);

    // PC wrap at the top of the address space
    popped.delete();
    step(1'b0, 1'b1, 15'o77777, 1'b1);
    repeat (10) step(1'b0, 1'b0, 15'd0, 1'b1);
    check("wrap_pc0", 32'(pk(0)), 'o77777);
    check("wrap_pc1", 32'(pk(1)), 0);
    check("wrap_pc2", 32'(pk(2)), 1);

    // one-cycle reset in the middle of operation
    step(1'b1, 1'b0, 15'd0, 1'b0);
    for (k = 0; k < 20 && last_count != 3; k++) step(1'b0, 1'b0, 15'd0, 1'b0);
    step(1'b0, 1'b0, 15'd0, 1'b0);
    step(1'b1, 1'b0, 15'd0, 1'b1);
    check("reset_mid_count", 32'(last_count), 0);
    check("reset_mid_valid", 32'(last_valid), 0);
    popped.delete();
    repeat (12) step(1'b0, 1'b0, 15'd0, 1'b1);
    check("after_reset_pc", 32'(pk(0)), 'o4000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) == 0, ($urandom % 25) == 0, ADDR_W'($urandom),
           ($urandom % 10) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
